// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master PicoRV32 native memory bus arbiter.
package mem_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
   typedef enum logic {MST_CPU = 1'b0, MST_DMA = 1'b1} mst_idx_t;

   function automatic logic [1:0] mst_onehot(input mst_idx_t m);
      return (m == MST_DMA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog for an outstanding bus transaction; saturates instead of wrapping.
module bus_timeout_counter #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic run,
   input  logic clear,
   output logic expired
);

   logic [15:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

   assign expired = (count >= 16'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the PicoRV32 native bus with round-robin/fixed priority
// and a watchdog that answers unacknowledged transactions with an error word.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int                 PRIORITY_MODE  = 0,
   parameter int                 TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   input  logic              m0_instr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic              m0_ready,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_instr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic              m1_ready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_valid,
   output logic              s_instr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic              s_ready,
   input  logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        grant,
   output logic              bus_error,
   output logic [ADDR_W-1:0] err_addr
);

   arb_state_t        state;
   mst_idx_t          last_winner;
   mst_idx_t          winner;
   logic              busy, sel_dma, g_valid;
   logic              done, tout, abort, fin, expired;
   logic [DATA_W-1:0] rsp;

   assign busy    = (state == ARB_BUSY);
   assign sel_dma = grant[1];
   assign g_valid = sel_dma ? m1_valid : m0_valid;
   assign done    = busy && g_valid && s_ready;
   assign tout    = busy && g_valid && !s_ready && expired;
   assign abort   = busy && !g_valid;
   assign fin     = done || tout;

   // A slave ready on the expiry cycle still counts as a normal completion.
   always_comb begin
      winner = MST_CPU;
      if (m0_valid && m1_valid) begin
         winner = ((PRIORITY_MODE != 0) || (last_winner == MST_DMA)) ? MST_CPU : MST_DMA;
      end else if (!m0_valid) begin
         winner = MST_DMA;
      end
   end

   assign s_valid = busy && g_valid && !tout;
   assign s_instr = busy && (sel_dma ? m1_instr : m0_instr);
   assign s_addr  = busy ? (sel_dma ? m1_addr  : m0_addr)  : '0;
   assign s_wdata = busy ? (sel_dma ? m1_wdata : m0_wdata) : '0;
   assign s_wstrb = busy ? (sel_dma ? m1_wstrb : m0_wstrb) : '0;

   // Responses are gated to zero off the completion cycle so downstream ORing stays clean.
   assign rsp       = tout ? ERR_DATA : s_rdata;
   assign m0_ready  = fin && !sel_dma;
   assign m1_ready  = fin && sel_dma;
   assign m0_rdata  = m0_ready ? rsp : '0;
   assign m1_rdata  = m1_ready ? rsp : '0;
   assign bus_error = tout;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ARB_IDLE;
         grant       <= 2'b00;
         last_winner <= MST_DMA;
         err_addr    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (m0_valid || m1_valid) begin
                  grant <= mst_onehot(winner);
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (fin || abort) begin
                  state <= ARB_IDLE;
                  grant <= 2'b00;
               end
               if (fin) begin
                  last_winner <= sel_dma ? MST_DMA : MST_CPU;
               end
               if (tout) begin
                  err_addr <= s_addr;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   bus_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .resetn  (resetn),
      .run     (busy && !s_ready),
      .clear   (!busy || fin || abort),
      .expired (expired)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: round-robin instance (dut0) and fixed-priority instance (dut1).
module tb_mem_bus_arbiter;

   typedef struct packed {
      logic [1:0]  mst;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_ready, slv_auto;
   logic [31:0] slv_rdata, s_rdata;

   logic        m0_ready, m1_ready, s_valid, s_instr, bus_error;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, err_addr;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   logic        f_m0_ready, f_m1_ready, f_s_valid, f_s_instr, f_bus_error;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata, f_err_addr;
   logic [3:0]  f_s_wstrb;
   logic [1:0]  f_grant;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t e;

   // Slave model: either echoes the inverted address or returns a programmed word.
   assign s_rdata = slv_auto ? ~s_addr : slv_rdata;

   mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut0 (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .bus_error(bus_error), .err_addr(err_addr)
   );

   mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut1 (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(f_m0_ready), .m0_rdata(f_m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(f_m1_ready), .m1_rdata(f_m1_rdata),
      .s_valid(f_s_valid), .s_instr(f_s_instr), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
      .s_wstrb(f_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(f_grant), .bus_error(f_bus_error), .err_addr(f_err_addr)
   );

   task automatic apply_reset();
      resetn = 1'b0;
      m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_ready = 1'b0; slv_auto = 1'b0; slv_rdata = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h80; m1_wdata = 32'h2; m1_wstrb = 4'h3;
      s_ready = 1'b1; slv_auto = 1'b0; slv_rdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || f_grant !== 2'b00) begin
         errors++; $display("FAIL reset_grant got=%b/%b exp=00", grant, f_grant);
      end
      checks++;
      if (s_valid !== 1'b0 || s_wstrb !== 4'h0 || s_addr !== 32'h0) begin
         errors++; $display("FAIL reset_slave got valid=%b wstrb=%h addr=%h exp 0", s_valid, s_wstrb, s_addr);
      end
      checks++;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL reset_ready got m0=%b m1=%b err=%b exp 0", m0_ready, m1_ready, bus_error);
      end
      checks++;
      if (err_addr !== 32'h0) begin
         errors++; $display("FAIL reset_err_addr got=%h exp=0", err_addr);
      end
   endtask

   task automatic test_single_read();
      apply_reset();
      m0_addr = 32'h0000_0100; m0_wstrb = 4'h0; m0_instr = 1'b1; m0_valid = 1'b1;
      exp_q.push_back('{2'b01, 32'h1234_5678, 1'b0});
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL sr_idle_grant got=%b exp=00", grant);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b01 || s_valid !== 1'b1 || s_addr !== 32'h0000_0100 || s_instr !== 1'b1) begin
         errors++; $display("FAIL sr_busy got grant=%b valid=%b addr=%h instr=%b exp 01 1 00000100 1",
                            grant, s_valid, s_addr, s_instr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (m0_ready !== 1'b0) begin
         errors++; $display("FAIL sr_early_ready got=%b exp=0", m0_ready);
      end
      @(posedge clk); #1 s_ready = 1'b1; slv_rdata = 32'h1234_5678;
      @(negedge clk);
      if (m0_ready || m1_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL sr_sb unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
         end else begin
            e = exp_q.pop_front();
            if ({m1_ready, m0_ready} !== e.mst || (m1_ready ? m1_rdata : m0_rdata) !== e.rdata || bus_error !== e.err) begin
               errors++; $display("FAIL sr_sb got ready=%b rdata=%h err=%b exp ready=%b rdata=%h err=%b",
                                  {m1_ready, m0_ready}, (m1_ready ? m1_rdata : m0_rdata), bus_error, e.mst, e.rdata, e.err);
            end
         end
      end
      @(posedge clk); #1 s_ready = 1'b0; m0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
         errors++; $display("FAIL sr_after got grant=%b m0_ready=%b m1_ready=%b exp 00 0 0", grant, m0_ready, m1_ready);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sr_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] tr [9];
      int n0, n1;
      tr = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      n0 = 0; n1 = 0;
      apply_reset();
      m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
      slv_auto = 1'b1; s_ready = 1'b1;
      exp_q.push_back('{2'b01, ~32'h0000_1000, 1'b0});
      exp_q.push_back('{2'b10, ~32'h0000_2000, 1'b0});
      exp_q.push_back('{2'b01, ~32'h0000_1000, 1'b0});
      exp_q.push_back('{2'b10, ~32'h0000_2000, 1'b0});
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         checks++;
         if (grant !== tr[k]) begin
            errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, grant, tr[k]);
         end
         checks++;
         if ((!m0_ready && m0_rdata !== 32'h0) || (!m1_ready && m1_rdata !== 32'h0)) begin
            errors++; $display("FAIL rr_idle_rdata[%0d] got m0=%h m1=%h exp 0 when not ready", k, m0_rdata, m1_rdata);
         end
         if (m0_ready || m1_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rr_sb unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
            end else begin
               e = exp_q.pop_front();
               if ({m1_ready, m0_ready} !== e.mst || (m1_ready ? m1_rdata : m0_rdata) !== e.rdata || bus_error !== e.err) begin
                  errors++; $display("FAIL rr_sb got ready=%b rdata=%h err=%b exp ready=%b rdata=%h err=%b",
                                     {m1_ready, m0_ready}, (m1_ready ? m1_rdata : m0_rdata), bus_error, e.mst, e.rdata, e.err);
               end
            end
         end
         if (m0_ready) n0++;
         if (m1_ready) n1++;
         @(posedge clk); #1;
         if (n0 == 2) m0_valid = 1'b0;
         if (n1 == 2) m1_valid = 1'b0;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rr_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_fixed_priority();
      logic [1:0] tr [7];
      int n0, n1;
      tr = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      n0 = 0; n1 = 0;
      apply_reset();
      m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00;
      slv_auto = 1'b1; s_ready = 1'b1;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checks++;
         if (f_grant !== tr[k]) begin
            errors++; $display("FAIL fp_grant[%0d] got=%b exp=%b", k, f_grant, tr[k]);
         end
         if (f_m0_ready) n0++;
         if (f_m1_ready) n1++;
         @(posedge clk); #1;
         if (n0 == 2) m0_valid = 1'b0;
         if (n1 == 1) m1_valid = 1'b0;
      end
      checks++;
      if (n0 != 2 || n1 != 1) begin
         errors++; $display("FAIL fp_ready_count got m0=%0d m1=%0d exp m0=2 m1=1", n0, n1);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      m1_addr = 32'hFFFF_0000; m1_wdata = 32'h55AA_1234; m1_wstrb = 4'hF; m1_valid = 1'b1;
      exp_q.push_back('{2'b10, 32'hDEAD_BEEF, 1'b1});
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++; $display("FAIL to_idle_grant got=%b exp=00", grant);
      end
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (s_valid !== 1'b1 || s_wstrb !== 4'hF || s_wdata !== 32'h55AA_1234 || s_addr !== 32'hFFFF_0000) begin
               errors++; $display("FAIL to_mux got valid=%b wstrb=%h wdata=%h addr=%h exp 1 f 55aa1234 ffff0000",
                                  s_valid, s_wstrb, s_wdata, s_addr);
            end
         end
         if (k < 8) begin
            checks++;
            if (m1_ready !== 1'b0 || bus_error !== 1'b0 || s_valid !== 1'b1) begin
               errors++; $display("FAIL to_early[%0d] got ready=%b err=%b valid=%b exp 0 0 1", k, m1_ready, bus_error, s_valid);
            end
         end else begin
            checks++;
            if (s_valid !== 1'b0) begin
               errors++; $display("FAIL to_svalid got=%b exp=0", s_valid);
            end
            if (m0_ready || m1_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL to_sb unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
               end else begin
                  e = exp_q.pop_front();
                  if ({m1_ready, m0_ready} !== e.mst || (m1_ready ? m1_rdata : m0_rdata) !== e.rdata || bus_error !== e.err) begin
                     errors++; $display("FAIL to_sb got ready=%b rdata=%h err=%b exp ready=%b rdata=%h err=%b",
                                        {m1_ready, m0_ready}, (m1_ready ? m1_rdata : m0_rdata), bus_error, e.mst, e.rdata, e.err);
                  end
               end
            end
         end
      end
      @(posedge clk); #1 m1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_addr !== 32'hFFFF_0000 || bus_error !== 1'b0 || grant !== 2'b00) begin
         errors++; $display("FAIL to_after got err_addr=%h err=%b grant=%b exp ffff0000 0 00", err_addr, bus_error, grant);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL to_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_coincidence();
      apply_reset();
      m0_addr = 32'h0000_2000; m0_valid = 1'b1;
      exp_q.push_back('{2'b01, 32'h0BAD_F00D, 1'b0});
      @(negedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 8) begin
            s_ready = 1'b1; slv_rdata = 32'h0BAD_F00D;
         end
         @(negedge clk);
         if (k == 8) begin
            checks++;
            if (s_valid !== 1'b1 || bus_error !== 1'b0) begin
               errors++; $display("FAIL co_flags got valid=%b err=%b exp 1 0", s_valid, bus_error);
            end
            if (m0_ready || m1_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL co_sb unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
               end else begin
                  e = exp_q.pop_front();
                  if ({m1_ready, m0_ready} !== e.mst || (m1_ready ? m1_rdata : m0_rdata) !== e.rdata || bus_error !== e.err) begin
                     errors++; $display("FAIL co_sb got ready=%b rdata=%h err=%b exp ready=%b rdata=%h err=%b",
                                        {m1_ready, m0_ready}, (m1_ready ? m1_rdata : m0_rdata), bus_error, e.mst, e.rdata, e.err);
                  end
               end
            end
         end
      end
      @(posedge clk); #1 m0_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (err_addr !== 32'h0 || exp_q.size() != 0) begin
         errors++; $display("FAIL co_after got err_addr=%h pending=%0d exp 0 0", err_addr, exp_q.size());
      end
   endtask

   task automatic test_abort();
      apply_reset();
      m0_addr = 32'h0000_0040; m0_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b01) begin
         errors++; $display("FAIL ab_grant got=%b exp=01", grant);
      end
      @(posedge clk); #1 m0_valid = 1'b0; s_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (m0_ready !== 1'b0 || s_valid !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL ab_drop got ready=%b valid=%b err=%b exp 0 0 0", m0_ready, s_valid, bus_error);
      end
      @(posedge clk); #1 s_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || m0_ready !== 1'b0) begin
         errors++; $display("FAIL ab_idle got grant=%b ready=%b exp 00 0", grant, m0_ready);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      m1_addr = 32'h0000_3000; m1_valid = 1'b1; slv_auto = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || s_valid !== 1'b1) begin
         errors++; $display("FAIL rm_busy got grant=%b valid=%b exp 10 1", grant, s_valid);
      end
      #2 resetn = 1'b0; s_ready = 1'b1;
      #1;
      checks++;
      if (s_valid !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL rm_async got valid=%b grant=%b m0=%b m1=%b err=%b exp all 0",
                            s_valid, grant, m0_ready, m1_ready, bus_error);
      end
      @(negedge clk);
      checks++;
      if (m1_ready !== 1'b0 || s_valid !== 1'b0) begin
         errors++; $display("FAIL rm_held got ready=%b valid=%b exp 0 0", m1_ready, s_valid);
      end
      @(posedge clk); #1 resetn = 1'b1;
      exp_q.push_back('{2'b10, ~32'h0000_3000, 1'b0});
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || m1_ready !== 1'b0) begin
         errors++; $display("FAIL rm_release got grant=%b ready=%b exp 00 0", grant, m1_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (m0_ready || m1_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL rm_sb unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
         end else begin
            e = exp_q.pop_front();
            if ({m1_ready, m0_ready} !== e.mst || (m1_ready ? m1_rdata : m0_rdata) !== e.rdata || bus_error !== e.err) begin
               errors++; $display("FAIL rm_sb got ready=%b rdata=%h err=%b exp ready=%b rdata=%h err=%b",
                                  {m1_ready, m0_ready}, (m1_ready ? m1_rdata : m0_rdata), bus_error, e.mst, e.rdata, e.err);
            end
         end
      end
      @(posedge clk); #1 m1_valid = 1'b0; s_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rm_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_timeout();
      test_coincidence();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
